modbus_uart_rx: RTL
===================

# modbus_uart_rx

Modbus RTU serial receiver that feeds the UART input port of `ModbusToWishbone`. It deserialises an asynchronous 8-bit line with optional parity and holds each byte for the consumer under a level/request handshake. It flags parity, framing and overflow faults per byte. It also emits the RTU end-of-frame `silence` pulse once the line has been idle for 3.5 character times.

## Interface
Parameters:
- `CLK_DIV`, 16: `clk` cycles per bit period; legal range 8..65535, must be even.
- `PARITY`, 1: 0 = none, 1 = even, 2 = odd.
- `SILENCE_BITS`, 39: idle bit periods that mark end of frame (3.5 chars × 11 bits, rounded up).

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous to `clk`, idle high.
- `dataOut` output 9: `[7:0]` is the byte; `[8]` is the received parity bit (0 when `PARITY`=0).
- `dataReceived` output 1: `dataOut` holds an unconsumed byte.
- `receiveReq` input 1: consumer takes the held byte this cycle.
- `parityError` output 1: the held byte failed its parity check.
- `framingError` output 1: the held byte had a low stop bit.
- `overflow` output 1: the held byte overwrote an unconsumed byte.
- `silence` output 1: one-cycle end-of-frame pulse.

## Operation
- `rx` passes through a 2-flop synchroniser. All logic below uses the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, PAR, STOP. A bit counter (0..7) and a divider counter (0..`CLK_DIV`-1) support it.
- IDLE to START happens when `rxs` falls. The divider loads `CLK_DIV/2`-1, so sampling lands mid-bit.
- START: at the mid-bit sample, `rxs`=1 is a false start and the FSM returns to IDLE with no output. `rxs`=0 moves to DATA.
- DATA samples every `CLK_DIV` cycles, LSB first, 8 bits. It then goes to PAR if `PARITY`≠0, else to STOP.
- PAR samples the parity bit. The even/odd check covers the data bits plus the parity bit.
- STOP samples the stop bit and commits the byte in the same cycle. The FSM then returns to IDLE immediately; the half stop bit remaining is not waited out.
- Commit loads `dataOut`, `parityError` and `framingError` (stop=0), and sets `dataReceived`=1.
- `overflow` at commit is 1 if `dataReceived` was 1 and `receiveReq` was 0 in that cycle; otherwise it is 0. The new byte always overwrites the held one.
- Accept is `receiveReq` && `dataReceived`. On accept with no commit in the same cycle, `dataReceived`, `parityError`, `framingError` and `overflow` clear next cycle. `dataOut` keeps its value.
- Accept and commit in the same cycle: the new byte is loaded, `dataReceived` stays 1, and `overflow`=0.
- `receiveReq` while `dataReceived`=0 is ignored.
- Silence timer:
  - It counts `clk` cycles while the FSM is in IDLE and `rxs`=1. Any `rxs`=0 or any non-IDLE state clears it.
  - At `SILENCE_BITS`×`CLK_DIV` it pulses `silence` for one cycle, then saturates.
  - It is armed only by a commit, so exactly one pulse follows each frame and there is no pulse after reset before the first byte.
  - It is independent of the handshake: `silence` may fire while `dataReceived`=1.

## Timing
- Reset values: FSM in IDLE, synchroniser flops at 1, `dataOut`=0, and `dataReceived`, `parityError`, `framingError`, `overflow`, `silence` all 0. The silence timer is disarmed.
- Latency from the `rx` falling edge to `dataReceived` rising:
  - `PARITY`≠0: 2 + `CLK_DIV`/2 + 10×`CLK_DIV` + 1 cycles.
  - `PARITY`=0: one `CLK_DIV` less.
- The consumer may hold `receiveReq` high indefinitely. Each committed byte is then accepted on its commit cycle plus one.
- `silence` asserts `SILENCE_BITS`×`CLK_DIV` cycles after the last commit, provided `rx` stays high.
- Reset asserted mid-byte aborts the byte with no partial output. After release, a line held low waits for a high level before a new start is recognised.
- Counter widths: divider is $clog2(`CLK_DIV`) bits; silence timer is $clog2(`SILENCE_BITS`×`CLK_DIV`+1) bits.

## Structure
- Shared package `modbus_pkg`: parity encoding constants (`PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`), the RX FSM state typedef, and the default `SILENCE_BITS`.
- One sub-module, `modbus_silence_timer`. Inputs: `clk`, `rst`, `arm` (commit), `idle` (IDLE && `rxs`). Output: `silence`. Parameter: terminal count.
- The synchroniser, FSM and handshake stay in the top-level module.

## Test plan
All scenarios use `CLK_DIV`=16 and `PARITY`=1 unless stated.
- Single byte 0x37 with parity 1, stop 1, `receiveReq` tied high: `dataOut`=0x137 and `dataReceived` high for one cycle, 2+8+160+1=171 cycles after the falling edge. All error flags 0.
- Frame 37 01 00 00 A5 FF 02 8C sent back-to-back, then line idle: 8 clean commits. One `silence` pulse 624 cycles after the last commit; no second pulse.
- Byte 0xA5 with a wrong parity bit: `parityError`=1 with the byte. Byte 0x02 with stop=0: `framingError`=1.
- Two bytes 0x01, 0x02 with `receiveReq`=0: after the second commit, `dataOut`[7:0]=0x02 and `overflow`=1. After one `receiveReq` all flags are 0.
- 4-cycle low glitch on `rx`: returns to IDLE, no commit, no `silence`. Reset pulsed at data bit 4: no commit, and the next full byte is received correctly.
- `PARITY`=0: byte 0xFF gives `dataOut`=0x0FF, 155 cycles after the edge.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus RTU serial receiver.
// Parity modes, RX state encoding and the parity check helper.
package modbus_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int SILENCE_BITS_DEF = 39;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } rx_state_t;

  // Even/odd check across the data bits plus the received parity bit.
  function automatic logic parity_err(
    input int         mode,
    input logic [7:0] data,
    input logic       pbit
  );
    logic ones;
    ones = ^data ^ pbit;
    if (mode == PARITY_EVEN) return ones;
    if (mode == PARITY_ODD)  return ~ones;
    return 1'b0;
  endfunction

endpackage

// File: rtl/modbus_silence_timer.sv
// RTU end-of-frame detector: one pulse after TERM idle-high cycles.
// Armed by each committed byte, disarmed by its own pulse.
module modbus_silence_timer #(
  parameter int TERM = 624
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic idle,
  output logic silence
);

  localparam int W = $clog2(TERM + 1);
  localparam logic [W-1:0] FULL = W'(TERM);
  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] cnt;
  logic         armed;

  // Count idle cycles, saturate at TERM, pulse once per arming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      armed   <= 1'b0;
      silence <= 1'b0;
    end else begin
      silence <= 1'b0;
      if (!idle)
        cnt <= '0;
      else if (cnt != FULL)
        cnt <= cnt + 1'b1;
      if (arm) begin
        armed <= 1'b1;
      end else if (armed && idle && cnt == LAST) begin
        armed   <= 1'b0;
        silence <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/modbus_uart_rx.sv
// Modbus RTU UART receiver with level/request byte handshake.
// Flags parity, framing and overflow per byte; emits RTU silence.
module modbus_uart_rx
  import modbus_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int PARITY       = PARITY_EVEN,
  parameter int SILENCE_BITS = SILENCE_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [8:0] dataOut,
  output logic       dataReceived,
  input  logic       receiveReq,
  output logic       parityError,
  output logic       framingError,
  output logic       overflow,
  output logic       silence
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);
  localparam bit HAS_PAR = (PARITY != PARITY_NONE);

  logic          s0;
  logic          s1;
  logic          rxs;
  logic [1:0]    fill;
  logic          rxs_d;
  logic          fall;
  rx_state_t     state;
  logic [DW-1:0] div;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          pbit;
  logic          commit;
  logic          accept;

  assign rxs    = s1;
  assign fall   = rxs_d & ~rxs;
  assign commit = (state == S_STOP) && (div == '0);
  assign accept = receiveReq & dataReceived;

  // Two-flop synchroniser; rxs_d only trusts samples taken after reset,
  // so a line held low through reset needs a high before a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0    <= 1'b1;
      s1    <= 1'b1;
      fill  <= 2'b00;
      rxs_d <= 1'b0;
    end else begin
      s0    <= rx;
      s1    <= s0;
      fill  <= {fill[0], 1'b1};
      rxs_d <= rxs & fill[1];
    end
  end

  // Bit FSM plus byte commit and consumer handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      div          <= '0;
      bitn         <= '0;
      shreg        <= '0;
      pbit         <= 1'b0;
      dataOut      <= '0;
      dataReceived <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            div   <= DIV_HALF;
          end
        end
        S_START: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else if (rxs) begin
            state <= S_IDLE;
          end else begin
            state <= S_DATA;
            div   <= DIV_LAST;
            bitn  <= '0;
          end
        end
        S_DATA: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else begin
            shreg <= {rxs, shreg[7:1]};
            div   <= DIV_LAST;
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7)
              state <= HAS_PAR ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else begin
            pbit  <= rxs;
            div   <= DIV_LAST;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (div != '0)
            div <= div - 1'b1;
          else
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        dataOut      <= {HAS_PAR ? pbit : 1'b0, shreg};
        parityError  <= parity_err(PARITY, shreg, pbit);
        framingError <= ~rxs;
        overflow     <= dataReceived & ~receiveReq;
        dataReceived <= 1'b1;
      end else if (accept) begin
        dataReceived <= 1'b0;
        parityError  <= 1'b0;
        framingError <= 1'b0;
        overflow     <= 1'b0;
      end
    end
  end

  modbus_silence_timer #(
    .TERM(SILENCE_BITS * CLK_DIV)
  ) u_sil (
    .clk    (clk),
    .rst    (rst),
    .arm    (commit),
    .idle   ((state == S_IDLE) && rxs),
    .silence(silence)
  );

endmodule
